// File: rtl/amp_spi_pkg.sv
// rtl/amp_spi_pkg.sv - shared types and constants for the amplifier SPI router
//   Provides the router FSM state type, default parameter values and the
//   chip-select bit positions within each channel's chip-select group.
package amp_spi_pkg;

    localparam int DEF_NUM_CH       = 8;
    localparam int DEF_NUM_CS       = 3;
    localparam int DEF_SYNC_STAGES  = 2;
    localparam int DEF_GUARD_CYCLES = 4;
    localparam int DEF_CNT_W        = 16;

    // Chip-select bit positions inside one channel's group
    localparam int CS_ADC_VGA  = 0;
    localparam int CS_DAC_VGA1 = 1;
    localparam int CS_DAC_VGA2 = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GUARD = 2'd1,
        ST_BUSY  = 2'd2,
        ST_BLANK = 2'd3
    } state_t;

endpackage

// File: rtl/amp_spi_csn_sync.sv
// rtl/amp_spi_csn_sync.sv - multi-flop synchroniser for the host SPI chip select
//   Ports: clk, rst (sync active-high, presets chain to 1), d (async input),
//   q (synchronised output, STAGES clocks behind d).
module amp_spi_csn_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_r;

    // Preset to 1 so a reset never looks like a frame start
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_r <= '1;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], d};
        end
    end

    assign q = sync_r[STAGES-1];

endmodule

// File: rtl/amp_spi_router.sv
// rtl/amp_spi_router.sv - host amp SPI port router to NUM_CH channel buses
//   Ports: wb_clk_i/wb_rst_i (sync active-high); selection request sel_wr_en,
//   sel_chan, sel_cs with status sel_pending, sel_err, frame_err; applied
//   selection act_chan/act_cs; frame_busy, frame_count; host SPI ampspi_*;
//   channel buses ch_sclk, ch_mosi, ch_miso, ch_csn (chip k of channel c at
//   c*NUM_CS+k, active low).
//   Optional macro AMP_SPI_BROADCAST_EN: accepts multi-channel masks and
//   rejects only a non-empty channel mask with an empty chip-select mask.
module amp_spi_router
    import amp_spi_pkg::*;
#(
    parameter int NUM_CH       = DEF_NUM_CH,
    parameter int NUM_CS       = DEF_NUM_CS,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
    parameter int CNT_W        = DEF_CNT_W
) (
    input  logic                     wb_clk_i,
    input  logic                     wb_rst_i,
    input  logic                     sel_wr_en,
    input  logic [NUM_CH-1:0]        sel_chan,
    input  logic [NUM_CS-1:0]        sel_cs,
    output logic                     sel_pending,
    output logic                     sel_err,
    output logic                     frame_err,
    output logic [NUM_CH-1:0]        act_chan,
    output logic [NUM_CS-1:0]        act_cs,
    output logic                     frame_busy,
    output logic [CNT_W-1:0]         frame_count,
    input  logic                     ampspi_csn,
    input  logic                     ampspi_sclk,
    input  logic                     ampspi_mosi,
    output logic                     ampspi_miso,
    output logic [NUM_CH-1:0]        ch_sclk,
    output logic [NUM_CH-1:0]        ch_mosi,
    input  logic [NUM_CH-1:0]        ch_miso,
    output logic [NUM_CH*NUM_CS-1:0] ch_csn
);

    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GUARD_LOAD = GW'(GUARD_CYCLES - 1);

    logic              csn_s;
    state_t            state, state_nxt;
    logic [NUM_CH-1:0] pend_chan;
    logic [NUM_CS-1:0] pend_cs;
    logic [GW-1:0]     guard_cnt;
    logic              req_ok;
    logic              req_acc;
    logic              apply;
    logic              count_frame;
    logic              set_ferr;
    logic              route_en;
    logic [NUM_CH-1:0] routed;

    amp_spi_csn_sync #(
        .STAGES (SYNC_STAGES)
    ) u_csn_sync (
        .clk (wb_clk_i),
        .rst (wb_rst_i),
        .d   (ampspi_csn),
        .q   (csn_s)
    );

`ifdef AMP_SPI_BROADCAST_EN
    assign req_ok = (sel_chan == '0) || (sel_cs != '0);
`else
    assign req_ok = $onehot0(sel_chan);
`endif

    assign req_acc = sel_wr_en && req_ok;

    always_comb begin
        state_nxt   = state;
        apply       = 1'b0;
        count_frame = 1'b0;
        set_ferr    = 1'b0;
        case (state)
            ST_IDLE: begin
                // A starting frame beats a pending selection change
                if (!csn_s) begin
                    state_nxt = ST_BUSY;
                end else if (sel_pending) begin
                    apply     = 1'b1;
                    state_nxt = ST_GUARD;
                end
            end
            ST_GUARD: begin
                if (!csn_s) begin
                    set_ferr  = 1'b1;
                    state_nxt = ST_BLANK;
                end else if (guard_cnt == '0) begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (csn_s) begin
                    count_frame = 1'b1;
                    state_nxt   = ST_IDLE;
                end
            end
            ST_BLANK: begin
                if (csn_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state       <= ST_IDLE;
            act_chan    <= '0;
            act_cs      <= '0;
            pend_chan   <= '0;
            pend_cs     <= '0;
            sel_pending <= 1'b0;
            sel_err     <= 1'b0;
            frame_err   <= 1'b0;
            frame_count <= '0;
            guard_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            sel_err <= sel_wr_en && !req_ok;

            if (apply) begin
                act_chan  <= pend_chan;
                act_cs    <= pend_cs;
                guard_cnt <= GUARD_LOAD;
            end else if (state == ST_GUARD && guard_cnt != '0) begin
                guard_cnt <= guard_cnt - 1'b1;
            end

            // A write in the same cycle as an apply becomes the next pending request
            if (req_acc) begin
                pend_chan   <= sel_chan;
                pend_cs     <= sel_cs;
                sel_pending <= 1'b1;
            end else if (apply) begin
                sel_pending <= 1'b0;
            end

            if (set_ferr) begin
                frame_err <= 1'b1;
            end else if (req_acc) begin
                frame_err <= 1'b0;
            end

            if (count_frame) begin
                frame_count <= frame_count + 1'b1;
            end
        end
    end

    assign frame_busy = (state == ST_BUSY);
    assign route_en   = (state != ST_GUARD) && (state != ST_BLANK);
    assign routed     = act_chan & {NUM_CH{route_en}};

    always_comb begin
        ch_sclk     = '1;
        ch_mosi     = '1;
        ch_csn      = '1;
        ampspi_miso = 1'b1;
        for (int c = 0; c < NUM_CH; c++) begin
            if (routed[c]) begin
                ch_sclk[c] = ampspi_sclk;
                ch_mosi[c] = ampspi_mosi;
                for (int k = 0; k < NUM_CS; k++) begin
                    if (act_cs[k]) begin
                        ch_csn[c*NUM_CS+k] = ampspi_csn;
                    end
                end
            end
        end
        // Scan downward so the lowest-index routed channel wins
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (routed[c]) begin
                ampspi_miso = ch_miso[c];
            end
        end
    end

endmodule

// File: tb/tb_amp_spi_router.sv
// tb/tb_amp_spi_router.sv - self-checking bench for amp_spi_router
module tb_amp_spi_router;

    localparam int NCH = 8;
    localparam int NCS = 3;
    localparam int GC  = 4;
    localparam int SS  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             sel_wr_en;
    logic [NCH-1:0]   sel_chan;
    logic [NCS-1:0]   sel_cs;
    logic             ampspi_csn, ampspi_sclk, ampspi_mosi;
    logic [NCH-1:0]   ch_miso;

    logic             sel_pending, sel_err, frame_err, frame_busy, ampspi_miso;
    logic [NCH-1:0]   act_chan, ch_sclk, ch_mosi;
    logic [NCS-1:0]   act_cs;
    logic [15:0]      frame_count;
    logic [NCH*NCS-1:0] ch_csn;

    logic             b_sel_pending, b_sel_err, b_frame_err, b_frame_busy, b_miso;
    logic [NCH-1:0]   b_act_chan, b_ch_sclk, b_ch_mosi;
    logic [NCS-1:0]   b_act_cs;
    logic [3:0]       b_frame_count;
    logic [NCH*NCS-1:0] b_ch_csn;

    int n_checks = 0;
    int n_errors = 0;
    int model_cnt = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    amp_spi_router #(.NUM_CH(NCH), .NUM_CS(NCS), .SYNC_STAGES(SS),
                     .GUARD_CYCLES(GC), .CNT_W(16)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst), .sel_wr_en(sel_wr_en),
        .sel_chan(sel_chan), .sel_cs(sel_cs), .sel_pending(sel_pending),
        .sel_err(sel_err), .frame_err(frame_err), .act_chan(act_chan),
        .act_cs(act_cs), .frame_busy(frame_busy), .frame_count(frame_count),
        .ampspi_csn(ampspi_csn), .ampspi_sclk(ampspi_sclk),
        .ampspi_mosi(ampspi_mosi), .ampspi_miso(ampspi_miso),
        .ch_sclk(ch_sclk), .ch_mosi(ch_mosi), .ch_miso(ch_miso), .ch_csn(ch_csn)
    );

    amp_spi_router #(.NUM_CH(NCH), .NUM_CS(NCS), .SYNC_STAGES(SS),
                     .GUARD_CYCLES(GC), .CNT_W(4)) dut_w4 (
        .wb_clk_i(clk), .wb_rst_i(rst), .sel_wr_en(sel_wr_en),
        .sel_chan(sel_chan), .sel_cs(sel_cs), .sel_pending(b_sel_pending),
        .sel_err(b_sel_err), .frame_err(b_frame_err), .act_chan(b_act_chan),
        .act_cs(b_act_cs), .frame_busy(b_frame_busy), .frame_count(b_frame_count),
        .ampspi_csn(ampspi_csn), .ampspi_sclk(ampspi_sclk),
        .ampspi_mosi(ampspi_mosi), .ampspi_miso(b_miso),
        .ch_sclk(b_ch_sclk), .ch_mosi(b_ch_mosi), .ch_miso(ch_miso), .ch_csn(b_ch_csn)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sel_write(input logic [NCH-1:0] chan, input logic [NCS-1:0] cs);
        sel_wr_en = 1'b1;
        sel_chan  = chan;
        sel_cs    = cs;
        tick();
        sel_wr_en = 1'b0;
    endtask

    // Independent reference of the routed bus for a given routed mask
    task automatic check_route(input string tag, input logic [NCH-1:0] rt, input logic [NCS-1:0] cs);
        logic [NCH*NCS-1:0] e_csn;
        logic [NCH-1:0]     e_sclk, e_mosi;
        logic               e_miso;
        e_csn  = '1;
        e_sclk = '1;
        e_mosi = '1;
        e_miso = 1'b1;
        for (int c = 0; c < NCH; c++) begin
            if (rt[c]) begin
                e_sclk[c] = ampspi_sclk;
                e_mosi[c] = ampspi_mosi;
                for (int k = 0; k < NCS; k++)
                    if (cs[k]) e_csn[c*NCS+k] = ampspi_csn;
            end
        end
        for (int c = 0; c < NCH; c++) begin
            if (rt[c]) begin
                e_miso = ch_miso[c];
                break;
            end
        end
        check_eq({tag, "_csn"},  32'(ch_csn),  32'(e_csn));
        check_eq({tag, "_sclk"}, 32'(ch_sclk), 32'(e_sclk));
        check_eq({tag, "_mosi"}, 32'(ch_mosi), 32'(e_mosi));
        check_eq({tag, "_miso"}, 32'(ampspi_miso), 32'(e_miso));
    endtask

    task automatic start_frame(input bit counted);
        if (counted) model_cnt++;
        exp_q.push_back(model_cnt);
        ampspi_csn = 1'b0;
    endtask

    task automatic frame_bits(input int n, input logic [NCH-1:0] rt, input logic [NCS-1:0] cs);
        for (int i = 0; i < n; i++) begin
            ampspi_sclk = 1'b0;
            ampspi_mosi = 1'($urandom);
            ch_miso     = NCH'($urandom);
            #1;
            check_route("lo", rt, cs);
            tick();
            ampspi_sclk = 1'b1;
            #1;
            check_route("hi", rt, cs);
            tick();
        end
        ampspi_sclk = 1'b0;
    endtask

    task automatic end_frame();
        int e;
        ampspi_csn = 1'b1;
        repeat (SS + 2) tick();
        if (exp_q.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            check_eq("frame_count", 32'(frame_count), 32'(e[15:0]));
            check_eq("frame_count_w4", 32'(b_frame_count), 32'(e[3:0]));
        end
    endtask

    initial begin
        rst = 1'b1;
        sel_wr_en = 1'b1;
        sel_chan = 8'h01;
        sel_cs = 3'h1;
        ampspi_csn = 1'b1;
        ampspi_sclk = 1'b0;
        ampspi_mosi = 1'b0;
        ch_miso = 8'h00;
        repeat (3) tick();
        sel_wr_en = 1'b0;
        rst = 1'b0;
        tick();

        // Reset state; write during reset must not stick
        check_route("rst", 8'h00, 3'h0);
        check_eq("rst_fc", 32'(frame_count), 32'd0);
        check_eq("rst_pend", 32'(sel_pending), 32'd0);
        check_eq("rst_act", 32'(act_chan), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_busy", 32'(frame_busy), 32'd0);

        // Select channel 2, dac_vga1
        sel_write(8'h04, 3'h2);
        check_eq("w1_pend", 32'(sel_pending), 32'd1);
        check_eq("w1_act_early", 32'(act_chan), 32'd0);
        tick();
        check_eq("w1_act", 32'(act_chan), 32'h04);
        check_eq("w1_pend_clr", 32'(sel_pending), 32'd0);
        for (int g = 0; g < GC; g++) begin
            check_route("guard", 8'h00, 3'h0);
            tick();
        end
        check_route("post_guard", 8'h04, 3'h2);
        start_frame(1'b1);
        frame_bits(16, 8'h04, 3'h2);
        check_eq("w1_busy", 32'(frame_busy), 32'd1);
        end_frame();

        // Request mid-frame waits for the frame to end
        start_frame(1'b1);
        frame_bits(4, 8'h04, 3'h2);
        sel_write(8'h01, 3'h1);
        check_eq("mid_pend", 32'(sel_pending), 32'd1);
        frame_bits(4, 8'h04, 3'h2);
        check_eq("mid_act", 32'(act_chan), 32'h04);
        end_frame();
        check_eq("mid_act_new", 32'(act_chan), 32'h01);
        repeat (GC) tick();

`ifdef AMP_SPI_BROADCAST_EN
        sel_write(8'h02, 3'h0);
        check_eq("bc_err", 32'(sel_err), 32'd1);
        tick();
        check_eq("bc_act_keep", 32'(act_chan), 32'h01);
        sel_write(8'h03, 3'h5);
        check_eq("bc_noerr", 32'(sel_err), 32'd0);
        tick();
        check_eq("bc_act", 32'(act_chan), 32'h03);
        repeat (GC) tick();
        start_frame(1'b1);
        frame_bits(8, 8'h03, 3'h5);
        end_frame();
`else
        sel_write(8'h03, 3'h1);
        check_eq("oh_err", 32'(sel_err), 32'd1);
        tick();
        check_eq("oh_err_pulse", 32'(sel_err), 32'd0);
        check_eq("oh_act_keep", 32'(act_chan), 32'h01);
        check_eq("oh_pend", 32'(sel_pending), 32'd0);
        start_frame(1'b1);
        frame_bits(8, 8'h01, 3'h1);
        end_frame();
`endif

        // Frame started during GUARD is blanked and not counted
        sel_write(8'h04, 3'h1);
        tick();
        start_frame(1'b0);
        frame_bits(12, 8'h00, 3'h0);
        end_frame();
        check_eq("guard_ferr", 32'(frame_err), 32'd1);
        sel_write(8'h00, 3'h0);
        check_eq("ferr_clr", 32'(frame_err), 32'd0);
        repeat (GC + 1) tick();

        // Counter wrap on the 4-bit instance after 17 frames
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_cnt = 0;
        tick();
        for (int f = 0; f < 17; f++) begin
            start_frame(1'b1);
            frame_bits(2, 8'h00, 3'h0);
            end_frame();
        end
        check_eq("wrap_w4", 32'(b_frame_count), 32'd1);
        check_eq("wrap_w16", 32'(frame_count), 32'd17);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/amp_spi_router.md
Name: amp_spi_router

Overview:
- Parametrised router from the single host-facing amplifier SPI port to NUM_CH amplifier channel buses, each with NUM_CS chip selects.
- Routing is purely combinational. The channel/chip selection is a registered, frame-safe latch.
- A selection write applies only when no SPI frame is in progress, followed by a guard interval, so a frame is never split across channels.
- Sits between system_spi_subordinate (the register source) and the board amp SPI pins. It also provides a frame counter and error flags.

Parameters:
NUM_CH, 8, number of amplifier channel buses
NUM_CS, 3, chip selects per channel (bit0 adc_vga, bit1 dac_vga1, bit2 dac_vga2)
SYNC_STAGES, 2, flops in the ampspi_csn synchroniser (min 2)
GUARD_CYCLES, 4, wb_clk_i cycles that outputs stay idle after a new selection is applied (min 1)
CNT_W, 16, frame counter width

Ports:
wb_clk_i  in  1  system clock (internal oscillator)
wb_rst_i  in  1  synchronous, active-high reset
sel_wr_en  in  1  one-cycle strobe: request a new selection
sel_chan  in  NUM_CH  requested channel mask
sel_cs  in  NUM_CS  requested chip-select mask
sel_pending  out  1  a request is waiting to be applied
sel_err  out  1  one-cycle pulse: request rejected
frame_err  out  1  sticky: a frame started during GUARD; cleared by reset or an accepted sel_wr_en
act_chan  out  NUM_CH  applied channel mask
act_cs  out  NUM_CS  applied chip-select mask
frame_busy  out  1  synchronised frame in progress
frame_count  out  CNT_W  completed routed frames, wraps
ampspi_csn, ampspi_sclk, ampspi_mosi  in  1 each  host SPI
ampspi_miso  out  1  host SPI return
ch_sclk, ch_mosi  out  NUM_CH  per-channel bus
ch_miso  in  NUM_CH  per-channel return
ch_csn  out  NUM_CH*NUM_CS  index c*NUM_CS+k = chip k of channel c, active low

Behaviour:
- **Reset** (wb_rst_i high at a wb_clk_i edge):
  - act_chan and act_cs = 0; pending cleared; state IDLE.
  - frame_count = 0; frame_err, sel_err, frame_busy = 0.
  - Synchroniser preset to 1.
- **Routing (combinational):**
  - Channel c is routed iff act_chan[c] is set and state is not GUARD or BLANK.
  - A routed channel gets ch_sclk = ampspi_sclk and ch_mosi = ampspi_mosi.
  - ch_csn[c*NUM_CS+k] = ampspi_csn if channel c is routed and act_cs[k] is set; otherwise 1.
  - All unrouted outputs are driven 1.
  - ampspi_miso = ch_miso of the lowest-index routed channel; 1 if no channel is routed.
- **Synchroniser:** csn_s is ampspi_csn after SYNC_STAGES flops.
- **Request validation:** on sel_wr_en, sel_chan must be zero or one-hot.
  - Invalid: sel_err pulses in the next cycle; pending and act_* are unchanged.
  - Valid: latch into pending registers and set sel_pending. A new write overwrites an existing pending request (last wins). Clears frame_err.
- **FSM:**
  - IDLE: if csn_s=0, go to BUSY. Else if pending, copy pending to act_*, clear sel_pending, load the guard counter with GUARD_CYCLES-1, go to GUARD. csn_s=0 takes priority over pending in the same cycle.
  - GUARD: outputs idle; counter decrements. If csn_s=0, set frame_err and go to BLANK. At count 0 with csn_s=1, go to IDLE.
  - BUSY: frame_busy=1. When csn_s=1, increment frame_count (wraps at 2^CNT_W) and go to IDLE. Pending requests wait.
  - BLANK: outputs idle, frame not counted. When csn_s=1, go to IDLE.
- **Latency:** from the sel_wr_en edge, act_* updates at cycle 2 when idle. Outputs are routed after GUARD_CYCLES further cycles.
- A sel_wr_en in the same cycle as wb_rst_i is ignored.

Optional Feature:
- Macro: AMP_SPI_BROADCAST_EN.
- Defined:
  - Any sel_chan mask is accepted, for simultaneous writes to several channels.
  - sel_cs may also be multi-bit.
  - MISO comes from the lowest-index routed channel.
  - sel_err is raised only for sel_chan != 0 with sel_cs == 0.
- Undefined: the one-hot rule above applies; multi-bit sel_cs is still allowed.

Decomposition:
- Package amp_spi_pkg holds:
  - FSM state typedef (IDLE, GUARD, BUSY, BLANK);
  - default parameter constants;
  - the chip-select bit index constants CS_ADC_VGA=0, CS_DAC_VGA1=1, CS_DAC_VGA2=2.
- One sub-module, amp_spi_csn_sync: parametrised synchroniser, preset to 1.
- Routing and FSM stay in the top module.

Test Plan:
- Reset, then probe outputs:
  - all ch_* = 1, ampspi_miso = 1, frame_count = 0.
- Write chan=0x04, cs=0x2 while idle:
  - act_chan = 0x04 at cycle 2;
  - after 4 guard cycles a 16-bit frame drives only ch_csn[7];
  - ch_miso[2] is returned on ampspi_miso;
  - frame_count = 1.
- Write chan=0x01 mid-frame on channel 2:
  - sel_pending = 1 and routing stays on channel 2 until csn rises;
  - then act_chan = 0x01 and frame_count increments.
- Build without the macro; write chan=0x03:
  - sel_err pulses once and act_chan is unchanged.
- Build with AMP_SPI_BROADCAST_EN; write chan=0x03:
  - both channels are driven;
  - MISO comes from channel 0.
- Drop csn during GUARD:
  - frame_err = 1; outputs stay 1 for the whole frame; frame_count is unchanged.
- Counter wrap: with CNT_W=4, run 17 frames:
  - frame_count = 1.
